// File: rtl/mcpu_pkg.sv
// Shared opcodes, FSM state encoding and instruction-field offsets for the mcpu.
// Field offsets are functions of the register-address and immediate widths.
package mcpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_ADDI = 3'd3;
    localparam logic [2:0] OP_LI   = 3'd4;
    localparam logic [2:0] OP_BEQ  = 3'd5;
    localparam logic [2:0] OP_JMP  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Instruction word is {op, rd, rs1, rs2, imm}, MSB first.
    function automatic int instr_width(int raw, int immw);
        return 3 + 3 * raw + immw;
    endfunction

    function automatic int op_lsb(int raw, int immw);
        return 3 * raw + immw;
    endfunction

    function automatic int rd_lsb(int raw, int immw);
        return 2 * raw + immw;
    endfunction

    function automatic int rs1_lsb(int raw, int immw);
        return raw + immw;
    endfunction

    function automatic int rs2_lsb(int immw);
        return immw;
    endfunction

endpackage

// File: rtl/mcpu_if.sv
// Instruction-memory fetch port: the CPU raises req with addr, memory answers with valid and data.
interface mcpu_if #(
    parameter int PCW = 4,
    parameter int IW  = 13
);
    logic           imem_req;
    logic [PCW-1:0] imem_addr;
    logic           imem_valid;
    logic [IW-1:0]  imem_data;

    modport master (output imem_req, imem_addr, input imem_valid, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_valid, imem_data);
endinterface

// File: rtl/mcpu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, flattened dump.
module mcpu_regfile #(
    parameter int  DW   = 8,
    parameter int  NREG = 4,
    localparam int RAW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RAW-1:0]      ra1_i,
    input  logic [RAW-1:0]      ra2_i,
    output logic [DW-1:0]       rd1_o,
    output logic [DW-1:0]       rd2_o,
    input  logic                we_i,
    input  logic [RAW-1:0]      wa_i,
    input  logic [DW-1:0]       wd_i,
    output logic [NREG*DW-1:0]  regs_flat_o
);

    logic [DW-1:0] regs_q [NREG];

    // NOTE: this array is reset because software relies on every register reading 0 after
    // reset; that forces flops rather than a RAM macro, which is fine at this size.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = regs_q[ra1_i];
    assign rd2_o = regs_q[ra2_i];

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat_o[g*DW +: DW] = regs_q[g];
    end

endmodule

// File: rtl/mcpu.sv
// Multi-cycle CPU: FETCH over the req/valid port, one-cycle EXEC, HALT parks the core.
// Define MCPU_TRACE_EN to add trace_pc/trace_instr outputs for the retiring instruction.
module mcpu
    import mcpu_pkg::*;
#(
    parameter int  DW   = 8,
    parameter int  NREG = 4,
    parameter int  PCW  = 4,
    parameter int  IMMW = 4,
    localparam int RAW  = $clog2(NREG),
    localparam int IW   = instr_width(RAW, IMMW)
) (
    input  logic                clk,
    input  logic                rst,
    mcpu_if.master              imem,
    output logic                retire,
    output logic                halted,
    output logic [NREG*DW-1:0]  regs_flat
`ifdef MCPU_TRACE_EN
    ,
    output logic [PCW-1:0]      trace_pc,
    output logic [IW-1:0]       trace_instr
`endif
);

    localparam int OP_L  = op_lsb(RAW, IMMW);
    localparam int RD_L  = rd_lsb(RAW, IMMW);
    localparam int RS1_L = rs1_lsb(RAW, IMMW);
    localparam int RS2_L = rs2_lsb(IMMW);

    state_e         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d, tgt;
    logic [IW-1:0]  ir_q, ir_d;
    logic           halted_q, halted_d;

    logic [2:0]      op;
    logic [RAW-1:0]  rd, rs1, rs2;
    logic [IMMW-1:0] imm;
    logic [DW-1:0]   rs1_val, rs2_val, wd, imm_zx;
    logic            we, taken;

    assign op     = ir_q[OP_L +: 3];
    assign rd     = ir_q[RD_L +: RAW];
    assign rs1    = ir_q[RS1_L +: RAW];
    assign rs2    = ir_q[RS2_L +: RAW];
    assign imm    = ir_q[IMMW-1:0];
    assign imm_zx = DW'(imm);
    assign tgt    = PCW'(imm);
    assign taken  = (op == OP_JMP) || (op == OP_BEQ && rs1_val == rs2_val);

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        wd = '0;
        case (op)
            OP_ADD:  wd = rs1_val + rs2_val;
            OP_SUB:  wd = rs1_val - rs2_val;
            OP_AND:  wd = rs1_val & rs2_val;
            OP_ADDI: wd = rs1_val + imm_zx;
            OP_LI:   wd = imm_zx;
            default: wd = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (imem.imem_valid) state_d = ST_EXEC;
            ST_EXEC:   state_d = (op == OP_HALT) ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        imem.imem_req = (state_q == ST_FETCH);
        retire        = (state_q == ST_EXEC);
        we            = (state_q == ST_EXEC) && (op <= OP_LI);
    end

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        if (state_q == ST_FETCH && imem.imem_valid) ir_d = imem.imem_data;
        if (state_q == ST_EXEC) begin
            if (op == OP_HALT) halted_d = 1'b1;
            else               pc_d = taken ? tgt : pc_q + PCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign halted         = halted_q;

    mcpu_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .ra1_i       (rs1),
        .ra2_i       (rs2),
        .rd1_o       (rs1_val),
        .rd2_o       (rs2_val),
        .we_i        (we),
        .wa_i        (rd),
        .wd_i        (wd),
        .regs_flat_o (regs_flat)
    );

`ifdef MCPU_TRACE_EN
    // pc and ir still hold the retiring instruction throughout EXEC.
    assign trace_pc    = pc_q;
    assign trace_instr = ir_q;
`endif

endmodule
